// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-to-RAM slave front end: FSM states and
// command encodings carried in the first two bits of every frame.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        TX
    } spi_state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shift_reg.sv
// Generic serial shift register used for both the MOSI capture path and the
// MISO launch path. `shifted` is the value the register takes on a shift.
module spi_shift_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             shift_en,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] shifted
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        shifted = MSB_FIRST ? {data_q[WIDTH-2:0], ser_in} : {ser_in, data_q[WIDTH-1:1]};
        data_d  = data_q;
        if (clr) begin
            data_d = '0;
        end else if (load) begin
            data_d = load_data;
        end else if (shift_en) begin
            data_d = shifted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave front end: deserialises {cmd, payload} frames for the RAM
// controller and serialises RAM read data back onto MISO.
module spi_slave_gen
    import spi_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 MOSI,
    input  logic                 tx_valid,
    input  logic [PAYLOAD_W-1:0] tx_data,
    output logic                 MISO,
    output logic                 rx_valid,
    output logic [PAYLOAD_W+1:0] rx_data,
    output logic                 frame_err,
    output logic                 cmd_err
);

    localparam int unsigned FRAME_W = PAYLOAD_W + 2;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] PAY_CNT   = CNT_W'(PAYLOAD_W);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_CNT   = CNT_W'(2);
    // Selects the bit that goes out first on MISO for the configured order.
    localparam logic [PAYLOAD_W-1:0] TX_HEAD = MSB_FIRST ?
        {1'b1, {(PAYLOAD_W-1){1'b0}}} : {{(PAYLOAD_W-1){1'b0}}, 1'b1};

    spi_state_e           state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic                 rd_addr_pend_q, rd_addr_pend_d;
    logic                 miso_q, miso_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
    logic                 frame_err_q, frame_err_d;
    logic                 cmd_err_q, cmd_err_d;

    logic                 rx_clr, rx_shift_en;
    logic                 tx_clr, tx_load, tx_shift_en;
    logic [FRAME_W-1:0]   rx_nxt;
    logic [PAYLOAD_W-1:0] tx_nxt;
    logic [1:0]           cmd_now;
    logic [FRAME_W-1:0]   rx_word;

    spi_shift_reg #(.WIDTH(FRAME_W), .MSB_FIRST(MSB_FIRST)) u_rx_sr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (rx_clr),
        .load      (1'b0),
        .shift_en  (rx_shift_en),
        .ser_in    (MOSI),
        .load_data ({FRAME_W{1'b0}}),
        .shifted   (rx_nxt)
    );

    spi_shift_reg #(.WIDTH(PAYLOAD_W), .MSB_FIRST(MSB_FIRST)) u_tx_sr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (tx_clr),
        .load      (tx_load),
        .shift_en  (tx_shift_en),
        .ser_in    (1'b0),
        .load_data (tx_data),
        .shifted   (tx_nxt)
    );

    // Both fields keep their own bit order, so LSB-first frames land with the
    // command in the low two bits of the shift register and need rotating.
    assign cmd_now = MSB_FIRST ? rx_nxt[1:0] : {rx_nxt[FRAME_W-1], rx_nxt[FRAME_W-2]};
    assign rx_word = MSB_FIRST ? rx_nxt : {rx_nxt[1:0], rx_nxt[FRAME_W-1:2]};

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        tx_cnt_d       = tx_cnt_q;
        rd_addr_pend_d = rd_addr_pend_q;
        miso_d         = miso_q;
        rx_valid_d     = 1'b0;
        rx_data_d      = rx_data_q;
        frame_err_d    = 1'b0;
        cmd_err_d      = 1'b0;
        rx_clr         = 1'b0;
        rx_shift_en    = 1'b0;
        tx_clr         = 1'b0;
        tx_load        = 1'b0;
        tx_shift_en    = 1'b0;

        if (SS_n) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            tx_cnt_d  = '0;
            miso_d    = 1'b0;
            rx_clr    = 1'b1;
            tx_clr    = 1'b1;
            if ((state_q inside {CHK_CMD, WRITE, READ_ADD, READ_DATA}) && (bit_cnt_q != FRAME_CNT)) begin
                frame_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    rx_shift_en = 1'b1;
                    bit_cnt_d   = ONE_CNT;
                    state_d     = CHK_CMD;
                end
                CHK_CMD: begin
                    rx_shift_en = 1'b1;
                    bit_cnt_d   = TWO_CNT;
                    case (cmd_now)
                        CMD_WR_ADDR, CMD_WR_DATA: state_d = WRITE;
                        CMD_RD_ADDR:              state_d = READ_ADD;
                        default:                  state_d = READ_DATA;
                    endcase
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (bit_cnt_q != FRAME_CNT) begin
                        rx_shift_en = 1'b1;
                        bit_cnt_d   = bit_cnt_q + ONE_CNT;
                        if (bit_cnt_q == LAST_CNT) begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = rx_word;
                            if (state_q == READ_ADD) begin
                                rd_addr_pend_d = 1'b1;
                            end
                            if (state_q == READ_DATA) begin
                                rd_addr_pend_d = 1'b0;
                                cmd_err_d      = !rd_addr_pend_q;
                                state_d        = TX;
                            end
                        end
                    end
                end
                TX: begin
                    // tx_cnt counts bits already launched; 0 means still waiting.
                    if (tx_cnt_q == '0) begin
                        if (tx_valid) begin
                            tx_load  = 1'b1;
                            miso_d   = |(tx_data & TX_HEAD);
                            tx_cnt_d = ONE_CNT;
                        end
                    end else if (tx_cnt_q != PAY_CNT) begin
                        tx_shift_en = 1'b1;
                        miso_d      = |(tx_nxt & TX_HEAD);
                        tx_cnt_d    = tx_cnt_q + ONE_CNT;
                    end else begin
                        miso_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            tx_cnt_q       <= '0;
            rd_addr_pend_q <= 1'b0;
            miso_q         <= 1'b0;
            rx_valid_q     <= 1'b0;
            rx_data_q      <= '0;
            frame_err_q    <= 1'b0;
            cmd_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            tx_cnt_q       <= tx_cnt_d;
            rd_addr_pend_q <= rd_addr_pend_d;
            miso_q         <= miso_d;
            rx_valid_q     <= rx_valid_d;
            rx_data_q      <= rx_data_d;
            frame_err_q    <= frame_err_d;
            cmd_err_q      <= cmd_err_d;
        end
    end

    assign MISO      = miso_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign frame_err = frame_err_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench for spi_slave_gen: an 8-bit MSB-first instance and a
// 12-bit LSB-first instance driven from one clock and reset.
module tb_spi_slave_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_ss_n = 1'b1, a_mosi = 1'b0, a_tx_valid = 1'b0;
    logic [7:0]  a_tx_data = '0;
    logic        a_miso, a_rx_valid, a_frame_err, a_cmd_err;
    logic [9:0]  a_rx_data;

    logic        b_ss_n = 1'b1, b_mosi = 1'b0, b_tx_valid = 1'b0;
    logic [11:0] b_tx_data = '0;
    logic        b_miso, b_rx_valid, b_frame_err, b_cmd_err;
    logic [13:0] b_rx_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_slave_gen #(.PAYLOAD_W(8), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .SS_n(a_ss_n), .MOSI(a_mosi),
        .tx_valid(a_tx_valid), .tx_data(a_tx_data), .MISO(a_miso),
        .rx_valid(a_rx_valid), .rx_data(a_rx_data),
        .frame_err(a_frame_err), .cmd_err(a_cmd_err)
    );

    spi_slave_gen #(.PAYLOAD_W(12), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .SS_n(b_ss_n), .MOSI(b_mosi),
        .tx_valid(b_tx_valid), .tx_data(b_tx_data), .MISO(b_miso),
        .rx_valid(b_rx_valid), .rx_data(b_rx_data),
        .frame_err(b_frame_err), .cmd_err(b_cmd_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Frame on the wire for the MSB-first instance: cmd[1], cmd[0], pay[7..0].
    task automatic a_send(input logic [1:0] cmd, input logic [7:0] pay, input int nbits);
        logic [9:0] f;
        f = {cmd, pay};
        a_ss_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            a_mosi = f[9-i];
            tick();
        end
        a_mosi = 1'b0;
    endtask

    // Frame on the wire for the LSB-first instance: cmd[0], cmd[1], pay[0..11].
    task automatic b_send(input logic [1:0] cmd, input logic [11:0] pay, input int nbits);
        logic [13:0] s;
        s = {pay, cmd[1], cmd[0]};
        b_ss_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            b_mosi = s[i];
            tick();
        end
        b_mosi = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (a_miso !== 1'b0) begin errors++; $display("FAIL rst_miso got %b exp 0", a_miso); end
        checks++; if (a_rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got %b exp 0", a_rx_valid); end
        checks++; if (a_rx_data !== 10'h000) begin errors++; $display("FAIL rst_rx_data got %h exp 000", a_rx_data); end
        checks++; if (a_frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err got %b exp 0", a_frame_err); end
        checks++; if (a_cmd_err !== 1'b0) begin errors++; $display("FAIL rst_cmd_err got %b exp 0", a_cmd_err); end
        checks++; if (b_rx_data !== 14'h0000) begin errors++; $display("FAIL rst_b_rx_data got %h exp 0000", b_rx_data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        logic [9:0] f;
        logic early;
        f = 10'b00_1010_0101;
        early = 1'b0;
        a_tx_valid = 1'b1;
        a_tx_data = 8'hFF;
        a_ss_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a_mosi = f[9-i];
            tick();
            if (i < 9 && a_rx_valid !== 1'b0) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL wr_early_valid got %b exp 0", early); end
        checks++; if (a_rx_valid !== 1'b1) begin errors++; $display("FAIL wr_rx_valid got %b exp 1", a_rx_valid); end
        checks++; if (a_rx_data !== 10'h0A5) begin errors++; $display("FAIL wr_rx_data got %h exp 0a5", a_rx_data); end
        checks++; if (a_frame_err !== 1'b0) begin errors++; $display("FAIL wr_frame_err got %b exp 0", a_frame_err); end
        a_mosi = 1'b1;
        tick();
        checks++; if (a_rx_valid !== 1'b0) begin errors++; $display("FAIL wr_valid_pulse got %b exp 0", a_rx_valid); end
        tick();
        tick();
        checks++; if (a_miso !== 1'b0) begin errors++; $display("FAIL wr_tx_ignored got %b exp 0", a_miso); end
        checks++; if (a_rx_data !== 10'h0A5) begin errors++; $display("FAIL wr_extra_bits got %h exp 0a5", a_rx_data); end
        a_tx_valid = 1'b0;
        a_ss_n = 1'b1;
        a_mosi = 1'b0;
        tick();
        checks++; if (a_frame_err !== 1'b0) begin errors++; $display("FAIL wr_end_frame_err got %b exp 0", a_frame_err); end
    endtask

    task automatic test_read_pair();
        logic [7:0] got;
        a_send(2'b10, 8'h33, 10);
        checks++; if (a_rx_data !== 10'h233) begin errors++; $display("FAIL rp_addr_data got %h exp 233", a_rx_data); end
        a_ss_n = 1'b1;
        tick();
        a_send(2'b11, 8'h00, 10);
        checks++; if (a_rx_valid !== 1'b1) begin errors++; $display("FAIL rp_rd_valid got %b exp 1", a_rx_valid); end
        checks++; if (a_rx_data !== 10'h300) begin errors++; $display("FAIL rp_rd_data got %h exp 300", a_rx_data); end
        checks++; if (a_cmd_err !== 1'b0) begin errors++; $display("FAIL rp_cmd_err got %b exp 0", a_cmd_err); end
        tick();
        tick();
        checks++; if (a_miso !== 1'b0) begin errors++; $display("FAIL rp_miso_wait got %b exp 0", a_miso); end
        a_tx_valid = 1'b1;
        a_tx_data = 8'hC3;
        tick();
        a_tx_valid = 1'b0;
        a_tx_data = 8'h00;
        got = '0;
        got[7] = a_miso;
        for (int i = 1; i < 8; i++) begin
            tick();
            got[7-i] = a_miso;
        end
        checks++; if (got !== 8'hC3) begin errors++; $display("FAIL rp_miso_bits got %h exp c3", got); end
        tick();
        checks++; if (a_miso !== 1'b0) begin errors++; $display("FAIL rp_miso_idle got %b exp 0", a_miso); end
        a_ss_n = 1'b1;
        tick();
        checks++; if (a_frame_err !== 1'b0) begin errors++; $display("FAIL rp_tx_frame_err got %b exp 0", a_frame_err); end
    endtask

    task automatic test_cmd_err();
        pulse_reset();
        a_send(2'b11, 8'hF0, 10);
        checks++; if (a_rx_valid !== 1'b1) begin errors++; $display("FAIL ce_rx_valid got %b exp 1", a_rx_valid); end
        checks++; if (a_cmd_err !== 1'b1) begin errors++; $display("FAIL ce_cmd_err got %b exp 1", a_cmd_err); end
        checks++; if (a_rx_data !== 10'h3F0) begin errors++; $display("FAIL ce_rx_data got %h exp 3f0", a_rx_data); end
        a_tx_valid = 1'b1;
        a_tx_data = 8'h80;
        tick();
        a_tx_valid = 1'b0;
        checks++; if (a_cmd_err !== 1'b0) begin errors++; $display("FAIL ce_cmd_err_pulse got %b exp 0", a_cmd_err); end
        checks++; if (a_miso !== 1'b1) begin errors++; $display("FAIL ce_tx_entered got %b exp 1", a_miso); end
        tick();
        checks++; if (a_miso !== 1'b0) begin errors++; $display("FAIL ce_tx_bit1 got %b exp 0", a_miso); end
        a_ss_n = 1'b1;
        tick();
    endtask

    task automatic test_frame_err();
        a_send(2'b01, 8'hC3, 6);
        a_ss_n = 1'b1;
        tick();
        checks++; if (a_frame_err !== 1'b1) begin errors++; $display("FAIL fe_flag got %b exp 1", a_frame_err); end
        checks++; if (a_rx_valid !== 1'b0) begin errors++; $display("FAIL fe_no_valid got %b exp 0", a_rx_valid); end
        tick();
        checks++; if (a_frame_err !== 1'b0) begin errors++; $display("FAIL fe_pulse got %b exp 0", a_frame_err); end
        a_send(2'b01, 8'hC3, 10);
        checks++; if (a_rx_valid !== 1'b1) begin errors++; $display("FAIL fe_next_valid got %b exp 1", a_rx_valid); end
        checks++; if (a_rx_data !== 10'h1C3) begin errors++; $display("FAIL fe_next_data got %h exp 1c3", a_rx_data); end
        a_ss_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_in_tx();
        a_send(2'b10, 8'h12, 10);
        a_ss_n = 1'b1;
        tick();
        a_send(2'b11, 8'h34, 10);
        a_tx_valid = 1'b1;
        a_tx_data = 8'hE0;
        tick();
        a_tx_valid = 1'b0;
        tick();
        tick();
        checks++; if (a_miso !== 1'b1) begin errors++; $display("FAIL rt_third_bit got %b exp 1", a_miso); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (a_miso !== 1'b0) begin errors++; $display("FAIL rt_miso got %b exp 0", a_miso); end
        checks++; if (a_rx_data !== 10'h000) begin errors++; $display("FAIL rt_rx_data got %h exp 000", a_rx_data); end
        checks++; if (a_rx_valid !== 1'b0 || a_frame_err !== 1'b0 || a_cmd_err !== 1'b0) begin
            errors++; $display("FAIL rt_pulses got %b%b%b exp 000", a_rx_valid, a_frame_err, a_cmd_err);
        end
        a_ss_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        a_send(2'b11, 8'h55, 10);
        checks++; if (a_cmd_err !== 1'b1) begin errors++; $display("FAIL rt_cmd_err got %b exp 1", a_cmd_err); end
        checks++; if (a_rx_data !== 10'h355) begin errors++; $display("FAIL rt_rx_data2 got %h exp 355", a_rx_data); end
        a_ss_n = 1'b1;
        tick();
        a_send(2'b10, 8'h01, 10);
        a_ss_n = 1'b1;
        tick();
        pulse_reset();
        a_send(2'b11, 8'h00, 10);
        checks++; if (a_cmd_err !== 1'b1) begin errors++; $display("FAIL rt_pend_cleared got %b exp 1", a_cmd_err); end
        a_ss_n = 1'b1;
        tick();
    endtask

    task automatic test_lsb_first();
        logic [11:0] got;
        b_send(2'b01, 12'hA53, 14);
        checks++; if (b_rx_valid !== 1'b1) begin errors++; $display("FAIL lsb_wr_valid got %b exp 1", b_rx_valid); end
        checks++; if (b_rx_data !== 14'h1A53) begin errors++; $display("FAIL lsb_wr_data got %h exp 1a53", b_rx_data); end
        b_ss_n = 1'b1;
        tick();
        b_send(2'b10, 12'h012, 14);
        checks++; if (b_rx_data !== 14'h2012) begin errors++; $display("FAIL lsb_ra_data got %h exp 2012", b_rx_data); end
        b_ss_n = 1'b1;
        tick();
        b_send(2'b11, 12'h000, 14);
        checks++; if (b_rx_data !== 14'h3000) begin errors++; $display("FAIL lsb_rd_data got %h exp 3000", b_rx_data); end
        checks++; if (b_cmd_err !== 1'b0) begin errors++; $display("FAIL lsb_cmd_err got %b exp 0", b_cmd_err); end
        b_tx_valid = 1'b1;
        b_tx_data = 12'h5A3;
        tick();
        b_tx_valid = 1'b0;
        b_tx_data = 12'h000;
        got = '0;
        got[0] = b_miso;
        for (int i = 1; i < 12; i++) begin
            tick();
            got[i] = b_miso;
        end
        checks++; if (got !== 12'h5A3) begin errors++; $display("FAIL lsb_miso_bits got %h exp 5a3", got); end
        tick();
        checks++; if (b_miso !== 1'b0) begin errors++; $display("FAIL lsb_miso_idle got %b exp 0", b_miso); end
        b_ss_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_pair();
        test_cmd_err();
        test_frame_err();
        test_reset_in_tx();
        test_lsb_first();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_gen.md
# spi_slave_gen

Parametrised SPI slave front end for the on-chip SPI-to-RAM path. It deserialises command frames from an SPI master into parallel words for the RAM controller and serialises RAM read data back onto MISO. Compared with the first-generation slave it adds configurable payload width and bit order, explicit read-address/read-data sequencing, and error flags for truncated frames and illegal command order. The block sits between the chip SPI pins and the RAM controller, and runs with SPI bit timing equal to `clk`, one bit per rising edge.

## Interface
- `PAYLOAD_W`, 8: payload bits per frame, legal range 4-16. The frame length is FRAME_W = PAYLOAD_W+2 (2 command bits, then payload).
- `MSB_FIRST`, 1: 1 means the MSB is shifted first on both MOSI and MISO; 0 means LSB first.
- `clk` input 1: single clock. Everything samples on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `SS_n` input 1: slave select, active low.
- `MOSI` input 1: serial data from the master.
- `tx_valid` input 1: RAM read data is valid this cycle.
- `tx_data` input PAYLOAD_W: RAM read data.
- `MISO` output 1: serial data to the master. Reset value 0.
- `rx_valid` output 1: one-cycle pulse, `rx_data` is valid. Reset value 0.
- `rx_data` output FRAME_W: {cmd[1:0], payload}. Reset value 0.
- `frame_err` output 1: one-cycle pulse when a frame is truncated. Reset value 0.
- `cmd_err` output 1: one-cycle pulse on an illegal read order. Reset value 0.

## Operation
- Commands (cmd = first two bits received): 00 write address, 01 write data, 10 read address, 11 read data.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX.
- IDLE -> CHK_CMD on the first edge that samples SS_n=0. That same edge samples bit 0 of the frame.
- CHK_CMD: the second edge samples cmd bit 1, then the state decodes the command.
  - cmd[1]=0 -> WRITE.
  - cmd=10 -> READ_ADD.
  - cmd=11 -> READ_DATA.
- Internal flag `rd_addr_pend`:
  - Set when a READ_ADD frame completes.
  - Cleared when a READ_DATA frame completes, and on reset.
- READ_DATA with `rd_addr_pend`=0: the frame is still received and `rx_valid` still pulses. `cmd_err` pulses in the same cycle as `rx_valid`.
- Frame completion: when the bit counter reaches FRAME_W bits, the word is loaded into `rx_data` and `rx_valid` pulses.
  - After a READ_DATA completion the state moves to TX.
  - After any other completion the state holds, and further MOSI bits are ignored until SS_n rises.
- TX:
  - Waits for `tx_valid`. `tx_data` is captured on the edge where `tx_valid`=1.
  - Over the next PAYLOAD_W edges, MISO drives one bit per edge in MSB_FIRST order.
  - MISO is then held at 0 and the state waits for SS_n to rise.
- `tx_valid` in any state other than TX is ignored.
- SS_n=1 from any state returns to IDLE on the next edge. The bit counter and TX counter clear, and MISO goes to 0.
  - If this happens before frame completion, `frame_err` pulses and no `rx_valid` is issued.
  - SS_n rising in TX does not raise `frame_err`.
- Reset mid-operation: every state, counter and output goes to its reset value immediately (asynchronous). `rd_addr_pend` clears.

## Timing
- Bit k of the frame (k = 0..FRAME_W-1) is sampled on the k-th edge with SS_n=0, counting from 0.
- `rx_data` and `rx_valid` are registered on the edge that samples bit FRAME_W-1. `rx_valid` is high for exactly the following cycle.
- `frame_err` is registered on the edge that samples SS_n=1 while a frame is partial. It is high for one cycle.
- MISO latency: the first payload bit appears one cycle after the `tx_valid` edge. The last bit is held until the edge PAYLOAD_W cycles after that.
- No back-to-back frames without SS_n high for at least 1 cycle. If SS_n stays low, the block does not restart a frame.
- Counter widths are $clog2(FRAME_W+1), saturating at FRAME_W. No wrap-around.

## Structure
- Package `spi_pkg` holds:
  - the state enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX);
  - the command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
- One sub-module, `spi_shift_reg`, parametrised by width and direction, is instantiated twice: the RX (MOSI) path and the TX (MISO) path.
- The top level contains the FSM, counters, `rd_addr_pend` and the error logic.

## Test plan
- Write frame, PAYLOAD_W=8, MSB_FIRST=1: SS_n low, MOSI sequence 00_1010_0101 -> `rx_valid` pulses 1 cycle after the 10th edge with `rx_data`=10'h0A5, and `frame_err`=0.
- Read pair: send 10_0011_0011, then SS_n high, then 11_xxxx_xxxx, then `tx_valid` with `tx_data`=8'hC3 -> MISO emits 1,1,0,0,0,0,1,1 starting one cycle after `tx_valid`. `cmd_err`=0.
- Read data sent first after reset (cmd 11) -> `rx_valid` and `cmd_err` pulse together, and the block still enters TX.
- SS_n raised after 6 bits -> `frame_err` pulses 1 cycle, no `rx_valid`, and the state returns to IDLE. The next full frame is received correctly.
- `rst_n` asserted during TX after 3 MISO bits -> MISO=0 and all outputs 0 immediately. A following read-data frame raises `cmd_err`.
- PAYLOAD_W=12, MSB_FIRST=0: write frame and read cycle -> bit order is LSB first on both MOSI and MISO, and `rx_data` is 14 bits wide.
